muxn_scan: RTL and testbench

Parametrised N-channel, W-bit registered selector; successor to the fixed 4-to-1, 2-bit combinational selector. It adds a registered output and three operating modes: direct select, automatic round-robin scan with a programmable dwell time, and hold. It sits between switch/peripheral inputs and display or LED logic. Scan mode time-multiplexes channels onto a single output without an external select driver.

---
 rtl/muxn_pkg.sv | 9 +
 rtl/muxn_comb.sv | 17 +
 rtl/muxn_scan.sv | 59 +++++
 tb/tb_muxn_scan.sv | 110 +++++++++++
 4 files changed

// File: rtl/muxn_pkg.sv
// muxn_pkg: mode encodings and width helper shared by the muxn_scan slice
package muxn_pkg;
  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_HOLD   = 2'b10;
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/muxn_comb.sv
// muxn_comb: combinational N:1 W-bit selector, out-of-range select yields zero
module muxn_comb
  import muxn_pkg::*;
#(
  parameter int W = 2,
  parameter int N = 4,
  localparam int SW = clog2_min1(N)
) (
  input  logic [N*W-1:0] x_i,
  input  logic [SW-1:0]  sel_i,
  output logic [W-1:0]   y_o
);
  always_comb begin
    y_o = '0;
    for (int i = 0; i < N; i++) y_o = (sel_i == SW'(i)) ? x_i[i*W +: W] : y_o;
  end
endmodule

// File: rtl/muxn_scan.sv
// muxn_scan: registered N-channel selector with direct, round-robin scan and hold modes
module muxn_scan
  import muxn_pkg::*;
#(
  parameter int W = 2,
  parameter int N = 4,
  parameter int DWELL = 4,
  localparam int SW = clog2_min1(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] x_i,
  input  logic [SW-1:0]  sel_i,
  input  logic [1:0]     mode_i,
  input  logic           en_i,
  output logic [W-1:0]   f_o,
  output logic [SW-1:0]  cur_o,
  output logic           wrap_o
);
  localparam int DW = $clog2(DWELL) + 1;
  logic [SW-1:0] cur_q, cur_d, base;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [W-1:0]  f_q, f_d, y;
  logic          wrap_q, wrap_d, dir, scan, last, adv, top;
  assign dir  = mode_i == MODE_DIRECT;
  assign scan = mode_i == MODE_SCAN;
  // an out-of-range pointer left over from direct mode restarts the scan at channel 0
  assign base = (32'(cur_q) >= N) ? '0 : cur_q;
  assign top  = 32'(base) == N - 1;
  assign last = dwell_q == DW'(DWELL - 1);
  assign adv  = scan && en_i && last;
  muxn_comb #(.W(W), .N(N)) u_sel (
    .x_i  (x_i),
    .sel_i(dir ? sel_i : cur_q),
    .y_o  (y)
  );
  always_comb begin
    cur_d   = dir ? sel_i : adv ? (top ? '0 : base + SW'(1)) : scan ? base : cur_q;
    dwell_d = dir ? '0 : (scan && en_i) ? (last ? '0 : dwell_q + DW'(1)) : dwell_q;
    f_d     = (dir || scan) ? y : f_q;
    wrap_d  = adv && top;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q   <= '0;
      dwell_q <= '0;
      f_q     <= '0;
      wrap_q  <= 1'b0;
    end else begin
      cur_q   <= cur_d;
      dwell_q <= dwell_d;
      f_q     <= f_d;
      wrap_q  <= wrap_d;
    end
  end
  assign f_o    = f_q;
  assign cur_o  = cur_q;
  assign wrap_o = wrap_q;
endmodule

// File: tb/tb_muxn_scan.sv
// tb_muxn_scan: directed checks of muxn_scan (N=4 main instance, N=3 for out-of-range select)
module tb_muxn_scan;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1;
  logic [7:0] x = 8'hE4;
  logic [1:0] sel = 2'd2, mode = 2'b00;
  logic [1:0] f, cur, f3, cur3;
  logic wrap, wrap3;
  int tests = 0, fails = 0, wraps = 0;
  logic [1:0] v;
  always #5 clk = ~clk;
  muxn_scan #(.W(2), .N(4), .DWELL(4)) dut (
    .clk(clk), .rst(rst), .x_i(x), .sel_i(sel), .mode_i(mode), .en_i(en),
    .f_o(f), .cur_o(cur), .wrap_o(wrap)
  );
  muxn_scan #(.W(2), .N(3), .DWELL(4)) dut3 (
    .clk(clk), .rst(rst), .x_i(x[5:0]), .sel_i(sel), .mode_i(mode), .en_i(en),
    .f_o(f3), .cur_o(cur3), .wrap_o(wrap3)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk3(input string tag, input logic [1:0] ef, input logic [1:0] ec, input logic ew);
    chk({tag, ".f"}, 32'(f), 32'(ef));
    chk({tag, ".cur"}, 32'(cur), 32'(ec));
    chk({tag, ".wrap"}, 32'(wrap), 32'(ew));
  endtask
  initial begin
    // reset for two cycles
    for (int k = 0; k < 2; k++) begin
      step();
      chk3("reset", 2'd0, 2'd0, 1'b0);
    end
    rst = 1'b0;
    step();
    chk3("release_direct", 2'd2, 2'd2, 1'b0);
    // direct sweep; channel i of 8'hE4 holds value i
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      step();
      chk3($sformatf("direct_sel%0d", i), 2'(i), 2'(i), 1'b0);
    end
    chk("n3_sel3.f", 32'(f3), 32'd0);
    chk("n3_sel3.cur", 32'(cur3), 32'd3);
    sel = 2'd2;
    step();
    chk("n3_sel2.f", 32'(f3), 32'd2);
    sel = 2'd0;
    step();
    // scan from cur=0, dwell=0
    mode = 2'b01;
    for (int k = 1; k <= 32; k++) begin
      step();
      if (wrap) wraps++;
      chk3($sformatf("scan_e%0d", k), 2'(((k - 1) / 4) % 4), 2'((k / 4) % 4), (k % 16) == 0);
    end
    chk("wrap_count", 32'(wraps), 32'd2);
    step();
    step();
    chk("pre_freeze.cur", 32'(cur), 32'd0);
    // en low mid-dwell: channel 0 data varies, pointer frozen
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      v = 2'(k + 1);
      x = {6'b111001, v};
      step();
      chk3($sformatf("freeze%0d", k), v, 2'd0, 1'b0);
    end
    en = 1'b1;
    x = 8'hE4;
    step();
    chk3("resume1", 2'd0, 2'd0, 1'b0);
    step();
    chk3("resume2", 2'd0, 2'd1, 1'b0);
    step();
    chk3("resume3", 2'd1, 2'd1, 1'b0);
    // hold and reserved mode ignore x
    for (int k = 0; k < 10; k++) begin
      mode = (k < 5) ? 2'b10 : 2'b11;
      x = 8'($urandom);
      step();
      chk3($sformatf("hold%0d", k), 2'd1, 2'd1, 1'b0);
    end
    // reset on the edge where cur=3 and dwell=3
    x = 8'hE4;
    mode = 2'b00;
    sel = 2'd3;
    step();
    mode = 2'b01;
    for (int k = 0; k < 3; k++) step();
    chk3("pre_rst", 2'd3, 2'd3, 1'b0);
    rst = 1'b1;
    step();
    chk3("mid_scan_rst", 2'd0, 2'd0, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk3($sformatf("restart%0d", k), 2'd0, (k == 4) ? 2'd1 : 2'd0, 1'b0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
